// File: rtl/fifo_pkt_reader_pkg.sv
// rtl/fifo_pkt_reader_pkg.sv - shared types and header helpers for fifo_pkt_reader
// Purpose: FSM state encoding, header length field position and the
//          header legality check used by the packet reader.
// Ports:   none (package).
package fifo_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CSUM
  } state_t;

  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 7;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  // A header is usable only if it carries at least one payload word and
  // no more than the configured maximum.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_len);
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// rtl/fifo_pkt_reader_if.sv - framed output stream interface of the packet reader
// Purpose: bundles the sop/eop framed valid/ready output beat.
// Signals: out_data (beat word), out_valid, out_ready (sink backpressure),
//          out_sop (header beat), out_eop (checksum beat).
// Modports: master = packet source, slave = packet sink.
interface fifo_pkt_reader_if #(
  parameter int width = 16
);

  logic [width-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sop;
  logic             out_eop;

  modport master (
    output out_data,
    output out_valid,
    output out_sop,
    output out_eop,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sop,
    input  out_eop,
    output out_ready
  );

endinterface

// File: rtl/fifo_pkt_reader_out_reg.sv
// rtl/fifo_pkt_reader_out_reg.sv - output beat register with hold-on-stall
// Purpose: single-entry output register. Holds data/valid/sop/eop while the
//          sink stalls and exposes the load enable to the producer.
// Ports:   clk, rst (sync active-high); load, load_data, load_sop, load_eop
//          (candidate beat); ready (sink); ld (register may load this cycle);
//          data, valid, sop, eop (registered beat).
module pkt_out_reg #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             load_sop,
  input  logic             load_eop,
  input  logic             ready,
  output logic             ld,
  output logic [width-1:0] data,
  output logic             valid,
  output logic             sop,
  output logic             eop
);

  // Register is free when empty or its current beat leaves this cycle.
  assign ld = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      sop   <= 1'b0;
      eop   <= 1'b0;
    end else if (ld) begin
      if (load) begin
        data  <= load_data;
        valid <= 1'b1;
        sop   <= load_sop;
        eop   <= load_eop;
      end else begin
        // Bubble: data is left as-is, framing flags cleared with valid.
        valid <= 1'b0;
        sop   <= 1'b0;
        eop   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_pkt_reader.sv
// rtl/fifo_pkt_reader.sv - drains header-prefixed packets from a FIFO into a framed stream
// Purpose: pops header + payload words from a show-ahead FIFO head, emits them
//          with sop on the header and a trailing XOR checksum beat with eop,
//          rejects and counts headers with an illegal length.
// Ports:   clk, rst (sync active-high); fifo_dout, fifo_pndng (FIFO head),
//          fifo_pop (combinational pop); out (framed stream, master);
//          err_len (rejection pulse); pkt_count (wrapping); err_count (saturating).
module fifo_pkt_reader
  import fifo_pkt_pkg::*;
#(
  parameter int width   = 16,
  parameter int max_len = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [width-1:0]    fifo_dout,
  input  logic                fifo_pndng,
  output logic                fifo_pop,
  fifo_pkt_reader_if.master   out,
  output logic                err_len,
  output logic [15:0]         pkt_count,
  output logic [7:0]          err_count
);

  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic [width-1:0]   checksum;
  logic               ld;
  logic               load;
  logic               load_sop;
  logic               load_eop;
  logic [width-1:0]   load_data;
  logic [LEN_W-1:0]   hdr_len;
  logic               hdr_ok;

  assign hdr_len = fifo_dout[LEN_MSB:LEN_LSB];
  assign hdr_ok  = len_legal(hdr_len, max_len);

  always_comb begin
    fifo_pop  = 1'b0;
    load      = 1'b0;
    load_sop  = 1'b0;
    load_eop  = 1'b0;
    load_data = fifo_dout;
    case (state)
      IDLE: begin
        // Illegal headers are popped too, so the FIFO never wedges on them.
        if (fifo_pndng && ld) begin
          fifo_pop = 1'b1;
          load     = hdr_ok;
          load_sop = 1'b1;
        end
      end
      PAYLOAD: begin
        if (fifo_pndng && ld) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
        end
      end
      CSUM: begin
        load      = 1'b1;
        load_data = checksum;
        load_eop  = 1'b1;
      end
      default: ;
    endcase
    if (rst) fifo_pop = 1'b0;
  end

  pkt_out_reg #(.width(width)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_sop  (load_sop),
    .load_eop  (load_eop),
    .ready     (out.out_ready),
    .ld        (ld),
    .data      (out.out_data),
    .valid     (out.out_valid),
    .sop       (out.out_sop),
    .eop       (out.out_eop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      checksum  <= '0;
      err_len   <= 1'b0;
      err_count <= '0;
      pkt_count <= '0;
    end else begin
      err_len <= 1'b0;
      if (out.out_valid && out.out_ready && out.out_eop) pkt_count <= pkt_count + 16'd1;
      case (state)
        IDLE: begin
          if (fifo_pndng && ld) begin
            if (hdr_ok) begin
              remaining <= hdr_len;
              checksum  <= '0;
              state     <= PAYLOAD;
            end else begin
              err_len <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
        end
        PAYLOAD: begin
          if (fifo_pndng && ld) begin
            // Checksum register already holds the last word when CSUM loads it.
            checksum  <= checksum ^ fifo_dout;
            remaining <= remaining - 1'b1;
            if (remaining == 1) state <= CSUM;
          end
        end
        CSUM: begin
          if (ld) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_pkt_reader.md
Name: fifo_pkt_reader

Overview:
- Downstream consumer of fifo_flops. Drains header-prefixed packets from the FIFO head (Dout/pndng/pop) and re-emits them on a valid/ready stream.
- Each emitted packet is framed with sop/eop and a trailing XOR checksum word.
- Malformed headers are rejected and counted.
- Sits between the FIFO and the packet sink in the same clock domain.

Parameters:
- width, 16, FIFO word width and output data width (matches fifo_flops bits).
- max_len, 8, largest legal payload length in words (1..255).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fifo_dout  in  width  FIFO head word. Valid whenever fifo_pndng=1 (show-ahead).
- fifo_pndng  in  1  FIFO non-empty.
- fifo_pop  out  1  combinational. Removes the head word at the next posedge.
- out_data  out  width  output word (registered).
- out_valid  out  1  output beat valid (registered).
- out_ready  in  1  sink accepts the beat when out_valid && out_ready.
- out_sop  out  1  marks the header beat.
- out_eop  out  1  marks the checksum beat.
- err_len  out  1  one-cycle pulse on header rejection.
- pkt_count  out  16  accepted packets, wraps.
- err_count  out  8  rejected headers, saturates at 255.

Behaviour:
- Reset: state=IDLE; out_valid, out_sop, out_eop, err_len, fifo_pop = 0; out_data, pkt_count, err_count, checksum, remaining-length counter = 0. Reset mid-packet abandons the packet without emitting eop. FIFO contents are untouched by this block.
- Header format: fifo_dout[7:0] = payload length L. Upper bits are a tag and are forwarded unchanged.
- Load enable: ld = !out_valid || out_ready (output register empty or draining this cycle).
- IDLE:
  - If fifo_pndng && ld, inspect the head.
  - Header is legal when 1 ≤ L ≤ max_len: fifo_pop=1; output register loads the header with sop=1; remaining=L; checksum=0; go PAYLOAD.
  - Header is illegal (L=0 or L>max_len): fifo_pop=1 (header discarded); err_len pulses the next cycle; err_count++; stay IDLE; out_valid unaffected.
- PAYLOAD:
  - If fifo_pndng && ld: fifo_pop=1; load the word with sop=0, eop=0; checksum ^= word; remaining--.
  - When the popped word has remaining==1, go CSUM.
  - If !fifo_pndng while ld: out_valid drops after the current beat is consumed (bubble). No pop, state held.
- CSUM: when ld, load checksum (including the final payload word) with eop=1; no pop; go IDLE.
- Output register: when !ld, out_data, out_valid, out_sop and out_eop are held stable (AXI-style hold). When ld and nothing is loaded, out_valid→0.
- Throughput: 1 word/cycle while pndng and out_ready stay high. Latency from pop to out_valid is 1 cycle. Total beats per packet = L+2.
- fifo_pop is never asserted when fifo_pndng=0 or in CSUM.
- A new header can be popped in the cycle after the CSUM load (back-to-back packets, no idle gap required).
- pkt_count increments on an accepted beat with out_eop=1. It wraps 0xFFFF→0.
- Simultaneous out_ready=0 with pndng=1: no pop. The head word is preserved in the FIFO.

Decomposition:
- Shared package fifo_pkt_pkg: state enum (IDLE, PAYLOAD, CSUM), header length field constants LEN_LSB=0, LEN_MSB=7, and a function for header legality.
- One natural sub-module: pkt_out_reg, the output register with hold-on-stall (data, valid, sop, eop, load/ready logic).
- FSM, counters and checksum stay in the top.

Test Plan:
- FIFO holds 0x0003, 0x1111, 0x2222, 0x4444; out_ready=1 → beats 0x0003(sop), 0x1111, 0x2222, 0x4444, 0x7777(eop) on consecutive cycles; 4 pops; pkt_count=1.
- Header 0x0000, then header 0x0009 (max_len=8) → both popped; err_len pulses twice; err_count=2; no out_valid; state IDLE.
- Legal 2-word packet with out_ready toggling 1,0,0,1,… → out_data/out_valid stable during stalls; no pop while stalled; 4 beats delivered in order.
- FIFO empties mid-payload for 3 cycles → out_valid=0 during the gap; resumes on refill; checksum correct; single eop.
- Reset asserted after the 1st payload beat of L=4, then a fresh packet L=1 (0xABCD) → outputs zero in the reset cycle; next packet is 0x0001(sop), 0xABCD, 0xABCD(eop); pkt_count=1.
- Two back-to-back L=1 packets, out_ready=1 → 6 beats in 6 consecutive cycles; pkt_count=2.
